// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding and owner constants for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-request round-robin picker with last-served register
// Ports: clk, reset (async active-low), req[0]=CPU / req[1]=loader,
//        lock (mask CPU while loader was last served), advance (a grant is
//        taken this cycle), valid (some request eligible), pick (winner index).
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       advance,
    output logic       valid,
    output logic       pick
);

    logic       last;
    logic [1:0] eff;

    // Lock keeps the loader as owner by hiding the CPU request.
    assign eff   = {req[1], req[0] & ~(lock & (last == OWNER_DBG))};
    assign valid = |eff;
    assign pick  = &eff ? ~last : eff[1];

    // Reset to loader so the CPU wins the first tie.
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            last <= OWNER_DBG;
        else if (advance)
            last <= pick;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU / loader) arbiter in front of a single-port RAM
// Ports: clk, reset (async active-low);
//        cpu_req/we/addr/wdata -> cpu_ack (1-cycle pulse), cpu_rdata (held);
//        dbg_req/we/addr/wdata -> dbg_ack, dbg_rdata; dbg_lock (only with
//        MEM_ARB_LOCK_EN defined) grants the loader exclusive ownership;
//        ram_addr/ram_wdata/ram_write -> RAM, ram_rdata <- RAM (registered);
//        busy (not IDLE), owner (0 = CPU, 1 = loader, current or last grant).
// Each access runs IDLE -> ACCESS -> CAPTURE, ack one cycle after CAPTURE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic              dbg_lock,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner
);

    state_t            state, state_nxt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lock, gnt_valid, gnt_idx, grant;

`ifdef MEM_ARB_LOCK_EN
    assign lock = dbg_lock;
`else
    assign lock = 1'b0;
`endif

    assign grant = (state == IDLE) && gnt_valid;

    // A port in its ack cycle is not eligible: its held req is the old request.
    rr_arb2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     ({dbg_req & ~dbg_ack, cpu_req & ~cpu_ack}),
        .lock    (lock),
        .advance (grant),
        .valid   (gnt_valid),
        .pick    (gnt_idx)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb
        state_nxt = (state == IDLE)   ? (grant ? ACCESS : IDLE) :
                    (state == ACCESS) ? CAPTURE : IDLE;

    always_comb begin
        busy      = state != IDLE;
        ram_write = (state == ACCESS) && lat_we;
        ram_addr  = (state != IDLE) ? lat_addr  : '0;
        ram_wdata = (state != IDLE) ? lat_wdata : '0;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            owner     <= OWNER_CPU;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            cpu_ack <= (state == CAPTURE) && (owner == OWNER_CPU);
            dbg_ack <= (state == CAPTURE) && (owner == OWNER_DBG);
            if (grant) begin
                owner     <= gnt_idx;
                lat_we    <= gnt_idx ? dbg_we    : cpu_we;
                lat_addr  <= gnt_idx ? dbg_addr  : cpu_addr;
                lat_wdata <= gnt_idx ? dbg_wdata : cpu_wdata;
            end
            // RAM data registered during ACCESS is valid throughout CAPTURE.
            if (state == CAPTURE && !lat_we) begin
                if (owner == OWNER_DBG)
                    dbg_rdata <= ram_rdata;
                else
                    cpu_rdata <= ram_rdata;
            end
        end

endmodule
